// File: rtl/m_uart_loader.sv
// m_uart_loader: boot-time instruction-memory loader.
// Receives a program image over an 8N1 UART line and writes it word by word into the
// instruction memory, holding the processor core in reset until the image is complete.
// Image format: 16-bit word count N (low byte first), then 4*N payload bytes, with each
// word sent low byte first.
//
// Ports:
//   w_clk      system clock, all logic on posedge
//   w_rst      asynchronous active-low reset
//   w_rxd      UART receive line (idle high, asynchronous to w_clk)
//   r_we       instruction-memory write enable, one-cycle pulse per word
//   r_addr     instruction-memory word address (held between writes)
//   r_wdata    instruction word (held between writes)
//   r_proc_rst active-high processor reset, released once the image is loaded
//   r_done     image loaded (sticky)
//   r_err      load failed: framing, length or checksum (sticky)
//
// Build option: define LOADER_CHECKSUM_EN to expect one trailing byte equal to the XOR of
// all payload bytes; a mismatch ends in the error state.
module m_uart_loader #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned MAX_WORDS    = 4096
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_rxd,
    output logic        r_we,
    output logic [11:0] r_addr,
    output logic [31:0] r_wdata,
    output logic        r_proc_rst,
    output logic        r_done,
    output logic        r_err
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    // ---------------- UART receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state_q, rx_state_d;
    logic             rxd_meta_q, rxd_sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             stb_q, stb_d;
    logic             ferr_q, ferr_d;

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            stb_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rxd_meta_q <= w_rxd;
            rxd_sync_q <= rxd_meta_q;
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            stb_q      <= stb_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (!rxd_sync_q) rx_state_d = RX_START;
            // Line back high at mid start bit: a glitch, not a frame.
            RX_START: if (cnt_q == CNT_HALF) rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt_q == CNT_LAST && bit_q == 3'd7) rx_state_d = RX_STOP;
            RX_STOP:  if (cnt_q == CNT_LAST) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        stb_d   = 1'b0;
        ferr_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
            end
            RX_START: if (cnt_q == CNT_HALF) cnt_d = '0;
            RX_DATA: if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                shift_d = {rxd_sync_q, shift_q[7:1]};
                bit_d   = bit_q + 1'b1;
            end
            RX_STOP: if (cnt_q == CNT_LAST) begin
                stb_d  = rxd_sync_q;
                ferr_d = !rxd_sync_q;
            end
            default: cnt_d = '0;
        endcase
    end

    // ---------------- Loader FSM ----------------
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_CNTL, S_CNTH, S_DATA, S_SUM, S_DONE, S_ERR} state_t;
    localparam state_t S_FIN = S_SUM;
    logic [7:0] sum_q, sum_d;
`else
    typedef enum logic [2:0] {S_CNTL, S_CNTH, S_DATA, S_DONE, S_ERR} state_t;
    localparam state_t S_FIN = S_DONE;
`endif

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d, n_full;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  lane_q, lane_d;
    logic [23:0] word_q, word_d;
    logic        we_q, we_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        proc_rst_q, proc_rst_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    assign n_full = {shift_q, n_q[7:0]};

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            state_q    <= S_CNTL;
            n_q        <= '0;
            idx_q      <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            proc_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            proc_rst_q <= proc_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CNTL: if (ferr_q) state_d = S_ERR;
                    else if (stb_q) state_d = S_CNTH;
            S_CNTH: if (ferr_q) state_d = S_ERR;
                    else if (stb_q) begin
                        if (32'(n_full) > MAX_WORDS) state_d = S_ERR;
                        else if (n_full == '0)      state_d = S_FIN;
                        else                        state_d = S_DATA;
                    end
            S_DATA: if (ferr_q) state_d = S_ERR;
                    else if (stb_q && lane_q == 2'd3 && idx_q == n_q - 16'd1) state_d = S_FIN;
`ifdef LOADER_CHECKSUM_EN
            S_SUM:  if (ferr_q) state_d = S_ERR;
                    else if (stb_q) state_d = (shift_q == sum_q) ? S_DONE : S_ERR;
`endif
            default: state_d = state_q;
        endcase
    end

    // Status flags are registered from the state, so r_proc_rst/r_done change the cycle
    // after the final write pulse.
    always_comb begin
        n_d        = n_q;
        idx_d      = idx_q;
        lane_d     = lane_q;
        word_d     = word_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        proc_rst_d = (state_q != S_DONE);
        done_d     = (state_q == S_DONE);
        err_d      = (state_q == S_ERR);
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            S_CNTL: if (stb_q) n_d[7:0] = shift_q;
            S_CNTH: if (stb_q) begin
                n_d[15:8] = shift_q;
                idx_d     = '0;
                lane_d    = '0;
`ifdef LOADER_CHECKSUM_EN
                sum_d     = '0;
`endif
            end
            S_DATA: if (stb_q) begin
                lane_d = lane_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                sum_d  = sum_q ^ shift_q;
`endif
                case (lane_q)
                    2'd0: word_d[7:0]   = shift_q;
                    2'd1: word_d[15:8]  = shift_q;
                    2'd2: word_d[23:16] = shift_q;
                    default: begin
                        we_d    = 1'b1;
                        addr_d  = idx_q[11:0];
                        wdata_d = {shift_q, word_q};
                        idx_d   = idx_q + 16'd1;
                    end
                endcase
            end
            default: ;
        endcase
    end

    assign r_we       = we_q;
    assign r_addr     = addr_q;
    assign r_wdata    = wdata_q;
    assign r_proc_rst = proc_rst_q;
    assign r_done     = done_q;
    assign r_err      = err_q;
endmodule
